// File: rtl/alu_exec_unit.sv
// Execute-stage ALU with valid/ready handshakes on both sides.
// Add/sub/logic/compare complete in one cycle; shifts step one bit per cycle.
module alu_exec_unit #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      field,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpSub  = 4'b1000;
  localparam logic [3:0] OpSll  = 4'b0001;
  localparam logic [3:0] OpSlt  = 4'b0010;
  localparam logic [3:0] OpSltu = 4'b0011;
  localparam logic [3:0] OpXor  = 4'b0100;
  localparam logic [3:0] OpSrl  = 4'b0101;
  localparam logic [3:0] OpSra  = 4'b1101;
  localparam logic [3:0] OpOr   = 4'b0110;
  localparam logic [3:0] OpAnd  = 4'b0111;

  typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

  state_e             r_state;
  logic               r_in_ready;
  logic               r_out_valid;
  logic [XLEN-1:0]    r_result;
  logic               r_zero;
  logic               r_illegal;
  logic [3:0]         r_field;
  logic [XLEN-1:0]    r_shreg;
  logic [SHAMT_W-1:0] r_cnt;

  logic [SHAMT_W-1:0] w_shamt;
  logic               w_is_shift;
  logic               w_illegal;
  logic               w_accept;
  logic [XLEN-1:0]    w_res;
  logic [XLEN-1:0]    w_shift1;
  logic [XLEN-1:0]    w_step;

  // One-bit shift in the direction selected by an SLL/SRL/SRA code.
  function automatic logic [XLEN-1:0] shift_one(input logic [3:0] f, input logic [XLEN-1:0] v);
    if (f[2:0] == 3'b001) begin
      shift_one = {v[XLEN-2:0], 1'b0};
    end else if (f[3]) begin
      shift_one = {v[XLEN-1], v[XLEN-1:1]};
    end else begin
      shift_one = {1'b0, v[XLEN-1:1]};
    end
  endfunction

  assign w_shamt    = op_b[SHAMT_W-1:0];
  assign w_accept   = in_valid & r_in_ready;
  assign w_shift1   = shift_one(field, op_a);
  assign w_step     = shift_one(r_field, r_shreg);
  assign w_is_shift = (field == OpSll) || (field == OpSrl) || (field == OpSra);

  always_comb begin
    w_res     = '0;
    w_illegal = 1'b0;
    case (field)
      OpAdd:  w_res = op_a + op_b;
      OpSub:  w_res = op_a - op_b;
      OpSlt:  w_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      OpSltu: w_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      OpXor:  w_res = op_a ^ op_b;
      OpOr:   w_res = op_a | op_b;
      OpAnd:  w_res = op_a & op_b;
      OpSll, OpSrl, OpSra: w_res = (w_shamt == '0) ? op_a : w_shift1;
      default: w_illegal = 1'b1;
    endcase
  end

  // The first shift step happens on the accept edge, so a shift by N
  // presents its result N cycles after accept (shamt 0 or 1 finish at once).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_illegal   <= 1'b0;
      r_field     <= '0;
      r_shreg     <= '0;
      r_cnt       <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_accept) begin
            r_field    <= field;
            r_in_ready <= 1'b0;
            if (w_is_shift && (w_shamt > SHAMT_W'(1))) begin
              r_shreg <= w_shift1;
              r_cnt   <= w_shamt - SHAMT_W'(1);
              r_state <= StShift;
            end else begin
              r_result    <= w_res;
              r_zero      <= (w_res == '0);
              r_illegal   <= w_illegal;
              r_out_valid <= 1'b1;
              r_state     <= StDone;
            end
          end
        end
        StShift: begin
          r_shreg <= w_step;
          r_cnt   <= r_cnt - SHAMT_W'(1);
          if (r_cnt == SHAMT_W'(1)) begin
            r_result    <= w_step;
            r_zero      <= (w_step == '0);
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= StDone;
          end
        end
        StDone: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= StIdle;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= StIdle;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit: functions, shift latency,
// output backpressure, mid-shift reset and illegal codes.
module tb_alu_exec_unit;

  localparam logic [3:0] OpAdd  = 4'b0000;
  localparam logic [3:0] OpSub  = 4'b1000;
  localparam logic [3:0] OpSll  = 4'b0001;
  localparam logic [3:0] OpSlt  = 4'b0010;
  localparam logic [3:0] OpSltu = 4'b0011;
  localparam logic [3:0] OpXor  = 4'b0100;
  localparam logic [3:0] OpSrl  = 4'b0101;
  localparam logic [3:0] OpSra  = 4'b1101;
  localparam logic [3:0] OpOr   = 4'b0110;
  localparam logic [3:0] OpAnd  = 4'b0111;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  field;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic        zero;
  logic        illegal;

  int n_pass  = 0;
  int n_total = 0;

  alu_exec_unit #(
    .XLEN    (32),
    .SHAMT_W (5)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .field     (field),
    .op_a      (op_a),
    .op_b      (op_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one op with out_ready=1, measure accept-to-out_valid latency, check outputs.
  task automatic do_op(input string tag, input logic [3:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] er, input logic ez,
                       input logic ei, input int elat);
    int lat;
    @(negedge clk);
    field     = f;
    op_a      = a;
    op_b      = b;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    field    = OpAdd;
    op_a     = 32'hDEAD_BEEF;
    op_b     = 32'h0000_0003;
    lat      = 1;
    while (!out_valid && lat <= 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, ".lat"}, 32'(lat), 32'(elat));
    check({tag, ".result"}, result, er);
    check({tag, ".zero"}, 32'(zero), 32'(ez));
    check({tag, ".illegal"}, 32'(illegal), 32'(ei));
    @(posedge clk);
    #1;
    check({tag, ".in_ready_back"}, 32'(in_ready), 32'd1);
  endtask

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    field     = '0;
    op_a      = '0;
    op_b      = '0;
    repeat (2) @(negedge clk);
    check("rst.in_ready", 32'(in_ready), 32'd1);
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.result", result, 32'd0);
    check("rst.zero", 32'(zero), 32'd0);
    check("rst.illegal", 32'(illegal), 32'd0);
    rst_n = 1'b1;

    do_op("add_wrap", OpAdd, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b0, 1'b0, 1);
    do_op("sub_zero", OpSub, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 1);
    do_op("slt_neg", OpSlt, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1);
    do_op("slt_pos", OpSlt, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1'b0, 1);
    do_op("sltu", OpSltu, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 1'b0, 1);
    do_op("and", OpAnd, 32'hFF00_FF00, 32'h0FF0_0FF0, 32'h0F00_0F00, 1'b0, 1'b0, 1);
    do_op("or", OpOr, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0, 1);
    do_op("sra4", OpSra, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1'b0, 4);
    do_op("sra4_pos", OpSra, 32'h7000_0000, 32'd4, 32'h0700_0000, 1'b0, 1'b0, 4);
    do_op("sll31", OpSll, 32'h0000_0001, 32'd31, 32'h8000_0000, 1'b0, 1'b0, 31);
    do_op("sll8", OpSll, 32'h0000_00FF, 32'h0000_0108, 32'h0000_FF00, 1'b0, 1'b0, 8);
    do_op("srl0", OpSrl, 32'h1234_5678, 32'h0000_0020, 32'h1234_5678, 1'b0, 1'b0, 1);
    do_op("srl1", OpSrl, 32'h8000_0000, 32'd1, 32'h4000_0000, 1'b0, 1'b0, 1);
    do_op("sra31", OpSra, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 1'b0, 31);

    // Backpressure: result held while out_ready=0, inputs ignored in DONE.
    @(negedge clk);
    field     = OpOr;
    op_a      = 32'hA5A5_0000;
    op_b      = 32'h0000_5A5A;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    field = OpAdd;
    op_a  = 32'd1;
    op_b  = 32'd1;
    check("hold.out_valid", 32'(out_valid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("hold.result", result, 32'hA5A5_5A5A);
      check("hold.out_valid_kept", 32'(out_valid), 32'd1);
      check("hold.in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("release.in_ready", 32'(in_ready), 32'd1);
    check("release.out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("release.no_accept", 32'(out_valid), 32'd0);

    // Reset in the middle of a long shift aborts it.
    @(negedge clk);
    field    = OpSrl;
    op_a     = 32'hFFFF_FFFF;
    op_b     = 32'd20;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("abort.out_valid", 32'(out_valid), 32'd0);
    check("abort.result", result, 32'd0);
    check("abort.in_ready", 32'(in_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(posedge clk);
    #1;
    check("abort.no_late_result", 32'(out_valid), 32'd0);
    do_op("xor", OpXor, 32'hF0F0_F0F0, 32'hFFFF_FFFF, 32'h0F0F_0F0F, 1'b0, 1'b0, 1);

    // Illegal codes, then a legal op clears the flag.
    do_op("ill_1001", 4'b1001, 32'd5, 32'd7, 32'd0, 1'b1, 1'b1, 1);
    do_op("ill_1110", 4'b1110, 32'hFFFF_FFFF, 32'd3, 32'd0, 1'b1, 1'b1, 1);
    do_op("after_ill", OpAdd, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
